// File: rtl/fp_result_packer_pkg.sv
// Shared definitions for the floating-point result packer: FSM encoding,
// operation-status and flag bit positions, and the canonical quiet NaNs.
package fp_result_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_DENORM,
    ST_ROUND,
    ST_OUT
  } state_e;

  // Bit positions inside in_op_status = {nan, clear_inf, zero, invalid}
  localparam int OPS_NAN_BIT     = 3;
  localparam int OPS_INF_BIT     = 2;
  localparam int OPS_ZERO_BIT    = 1;
  localparam int OPS_INVALID_BIT = 0;

  // Bit positions inside out_flags = {invalid, overflow, underflow, inexact}
  localparam int FL_INVALID   = 3;
  localparam int FL_OVERFLOW  = 2;
  localparam int FL_UNDERFLOW = 1;
  localparam int FL_INEXACT   = 0;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/fp_rne_rounder.sv
// Combinational round-to-nearest-even incrementer over {ovf, int, fraction}
// using the trailing guard/round/sticky bits.
module fp_rne_rounder #(
  parameter int MANT_WIDTH = 23
) (
  input  logic [MANT_WIDTH+4:0] sig_i,
  output logic [MANT_WIDTH+1:0] sig_o,
  output logic                  inexact_o
);

  logic lsb, guard, round_bit, sticky, round_up;

  assign lsb       = sig_i[3];
  assign guard     = sig_i[2];
  assign round_bit = sig_i[1];
  assign sticky    = sig_i[0];

  // Ties (guard only) round up only when that makes the kept LSB even.
  assign round_up  = guard & (round_bit | sticky | lsb);
  assign inexact_o = guard | round_bit | sticky;
  assign sig_o     = sig_i[MANT_WIDTH+4:3] + {{(MANT_WIDTH+1){1'b0}}, round_up};

endmodule

// File: rtl/fp_result_packer.sv
// Normalises, denormalises, rounds and packs an internal FP result into an
// IEEE-754 word with exception flags, one shift step per clock.
module fp_result_packer
  import fp_result_packer_pkg::*;
#(
  parameter bit IS_DOUBLE  = 1'b0,
  parameter int EXP_WIDTH  = IS_DOUBLE ? 11 : 8,
  parameter int MANT_WIDTH = IS_DOUBLE ? 52 : 23
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_sign,
  input  logic signed [EXP_WIDTH+1:0]       in_exp,
  input  logic [MANT_WIDTH+4:0]             in_sig,
  input  logic [3:0]                        in_op_status,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0]     out_result,
  output logic [3:0]                        out_flags
);

  localparam int XW = EXP_WIDTH + 2;
  localparam int SW = MANT_WIDTH + 5;
  localparam int RW = EXP_WIDTH + MANT_WIDTH + 1;

  localparam logic signed [XW-1:0] EXP_ONE   = XW'(1);
  localparam logic signed [XW-1:0] EXP_INF   = XW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [XW-1:0] EXP_FLOOR = XW'(-(MANT_WIDTH + 3));
  localparam logic [EXP_WIDTH-1:0]  EXP_ONES  = '1;
  localparam logic [EXP_WIDTH-1:0]  EXP_ZERO  = '0;
  localparam logic [MANT_WIDTH-1:0] FRAC_ZERO = '0;
  localparam logic [RW-1:0]         QNAN      = IS_DOUBLE ? RW'(QNAN64) : RW'(QNAN32);

  state_e                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [XW-1:0]    exp_q, exp_d;
  logic [SW-1:0]           sig_q, sig_d;
  logic [RW-1:0]           result_q, result_d;
  logic [3:0]              flags_q, flags_d;

  logic signed [XW-1:0]    exp_inc, exp_dec;
  logic [SW-1:0]           sig_rshift, sig_lshift, sig_collapse;

  assign exp_inc      = exp_q + EXP_ONE;
  assign exp_dec      = exp_q - EXP_ONE;
  // Right shifts fold the dropped bit into sticky so rounding stays exact.
  assign sig_rshift   = {1'b0, sig_q[SW-1:2], sig_q[1] | sig_q[0]};
  assign sig_lshift   = {sig_q[SW-2:0], 1'b0};
  assign sig_collapse = {{(SW-1){1'b0}}, |sig_q};

  // Special results are decided straight from the inputs at accept time.
  logic [RW-1:0] spec_result;
  logic [3:0]    spec_flags;

  always_comb begin
    spec_result = {in_sign, EXP_ZERO, FRAC_ZERO};
    spec_flags  = '0;
    if (in_op_status[OPS_INVALID_BIT] || in_op_status[OPS_NAN_BIT]) begin
      spec_result             = QNAN;
      spec_flags[FL_INVALID]  = in_op_status[OPS_INVALID_BIT];
    end else if (in_op_status[OPS_INF_BIT]) begin
      spec_result = {in_sign, EXP_ONES, FRAC_ZERO};
    end
  end

  logic [MANT_WIDTH+1:0]   rnd_sig;
  logic                    rnd_inexact;

  fp_rne_rounder #(.MANT_WIDTH(MANT_WIDTH)) u_rounder (
    .sig_i     (sig_q),
    .sig_o     (rnd_sig),
    .inexact_o (rnd_inexact)
  );

  logic                    rnd_carry;
  logic [MANT_WIDTH:0]     rnd_mant;
  logic signed [XW-1:0]    rnd_exp;
  logic [EXP_WIDTH-1:0]    rnd_field;
  logic [RW-1:0]           rnd_result;
  logic [3:0]              rnd_flags;

  // A subnormal whose rounding carries into the integer bit keeps exp==1,
  // so it packs naturally as the smallest normal.
  always_comb begin
    rnd_carry  = rnd_sig[MANT_WIDTH+1];
    rnd_mant   = rnd_carry ? rnd_sig[MANT_WIDTH+1:1] : rnd_sig[MANT_WIDTH:0];
    rnd_exp    = rnd_carry ? exp_inc : exp_q;
    rnd_field  = rnd_mant[MANT_WIDTH] ? rnd_exp[EXP_WIDTH-1:0] : EXP_ZERO;
    rnd_result = {sign_q, rnd_field, rnd_mant[MANT_WIDTH-1:0]};
    rnd_flags  = '0;
    rnd_flags[FL_INEXACT]   = rnd_inexact;
    rnd_flags[FL_UNDERFLOW] = (rnd_field == EXP_ZERO) && rnd_inexact;
    if (rnd_exp >= EXP_INF) begin
      rnd_result             = {sign_q, EXP_ONES, FRAC_ZERO};
      rnd_flags              = '0;
      rnd_flags[FL_OVERFLOW] = 1'b1;
      rnd_flags[FL_INEXACT]  = 1'b1;
    end
  end

  // NOTE: every _d gets its current value first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_d    = sig_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = in_exp;
          sig_d  = in_sig;
          if (|in_op_status) begin
            result_d = spec_result;
            flags_d  = spec_flags;
            state_d  = ST_OUT;
          end else begin
            state_d  = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (sig_q == '0) begin
          result_d = {sign_q, EXP_ZERO, FRAC_ZERO};
          flags_d  = '0;
          state_d  = ST_OUT;
        end else if (sig_q[SW-1]) begin
          sig_d   = sig_rshift;
          exp_d   = exp_inc;
          state_d = (exp_inc < EXP_ONE) ? ST_DENORM : ST_ROUND;
        end else if (!sig_q[SW-2] && (exp_q > EXP_ONE)) begin
          sig_d = sig_lshift;
          exp_d = exp_dec;
        end else begin
          state_d = (exp_q < EXP_ONE) ? ST_DENORM : ST_ROUND;
        end
      end
      ST_DENORM: begin
        if (exp_q <= EXP_FLOOR) begin
          sig_d   = sig_collapse;
          exp_d   = EXP_ONE;
          state_d = ST_ROUND;
        end else if (exp_q < EXP_ONE) begin
          sig_d = sig_rshift;
          exp_d = exp_inc;
          if (exp_inc == EXP_ONE) state_d = ST_ROUND;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        result_d = rnd_result;
        flags_d  = rnd_flags;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sig_q    <= sig_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_OUT);
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_result_packer.sv
// Self-checking bench for fp_result_packer (binary32): directed vectors,
// handshake/reset sequences and random stimulus against a value-level model.
module tb_fp_result_packer;

  localparam int LAT_MAX = 23 + 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_sig;
  logic [3:0]  in_op_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  fp_result_packer #(.IS_DOUBLE(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_sig       (in_sig),
    .in_op_status (in_op_status),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic check_latency(input string name, input int lat, input int limit);
    total++;
    if (lat > limit) begin
      bad++;
      $display("FAIL %s: latency %0d exceeds %0d", name, lat, limit);
    end
  endtask

  // Value-level reference: sig is an integer scaled by 2^(exp-127-26); round
  // that exact value to binary32 with round-to-nearest-even.
  function automatic logic [35:0] ref_pack(input logic sign, input int exp,
                                           input logic [27:0] sig, input logic [3:0] st);
    longint n, m, rem, half;
    int     p, e, big_e, q, sh, biased;
    bit     inexact;
    if (st[0] || st[3]) return {st[0], 3'b000, 32'h7FC0_0000};
    if (st[2]) return {4'b0000, sign, 8'hFF, 23'h0};
    if (st[1]) return {4'b0000, sign, 31'h0};
    n = longint'(sig);
    if (n == 0) return {4'b0000, sign, 31'h0};
    e = exp - 153;
    p = 0;
    for (int i = 0; i < 28; i++) if (sig[i]) p = i;
    big_e   = p + e;
    q       = (big_e - 23 > -149) ? big_e - 23 : -149;
    sh      = q - e;
    inexact = 1'b0;
    if (sh <= 0) begin
      m = n << (-sh);
    end else if (sh > 40) begin
      m = 0;
      inexact = 1'b1;
    end else begin
      m    = n >> sh;
      rem  = n - (m << sh);
      half = longint'(1) << (sh - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && m[0])) m++;
    end
    if (m >= (longint'(1) << 24)) begin
      m = m >> 1;
      q++;
    end
    if (m >= (longint'(1) << 23)) begin
      biased = q + 150;
      if (biased >= 255) return {4'b0101, sign, 8'hFF, 23'h0};
      return {3'b000, inexact, sign, biased[7:0], m[22:0]};
    end
    return {2'b00, inexact, inexact, sign, 8'h00, m[22:0]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one transaction, waits (bounded) for out_valid, holds out_ready low
  // for 'hold' cycles, then releases the result.
  task automatic run_txn(input logic sign, input int exp, input logic [27:0] sig,
                         input logic [3:0] st, input int hold,
                         output logic [31:0] res, output logic [3:0] fl,
                         output int lat, output bit ok);
    @(negedge clk);
    in_valid     = 1'b1;
    in_sign      = sign;
    in_exp       = 10'(exp);
    in_sig       = sig;
    in_op_status = st;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ok  = out_valid;
    res = out_result;
    fl  = out_flags;
    if (!ok) begin
      do_reset();
    end else begin
      repeat (hold) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic        sign;
    int          exp;
    logic [27:0] sig;
    logic [3:0]  st;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    bit          ok;
    logic [35:0] want;
    int          w;

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0;
    in_sig = '0; in_op_status = '0; out_ready = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_result", out_result, 0);
    check("reset out_flags", out_flags, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //            sign  exp   sig           status   result          flags
    tbl.push_back('{1'b0, 127, 28'h600_0000, 4'b0000, 32'h3FC0_0000, 4'b0000}); // 1.5
    tbl.push_back('{1'b0, 127, 28'h800_0000, 4'b0000, 32'h4000_0000, 4'b0000}); // 2.0 overflow bit
    tbl.push_back('{1'b0, 127, 28'h7FF_FFFC, 4'b0000, 32'h4000_0000, 4'b0001}); // round carry
    tbl.push_back('{1'b0, 127, 28'h400_0000, 4'b0111, 32'h7FC0_0000, 4'b1000}); // inf*0
    tbl.push_back('{1'b1, 127, 28'h400_0000, 4'b0100, 32'hFF80_0000, 4'b0000}); // -inf
    tbl.push_back('{1'b1,   5, 28'h400_0000, 4'b0010, 32'h8000_0000, 4'b0000}); // -0
    tbl.push_back('{1'b0,   5, 28'h400_0000, 4'b1000, 32'h7FC0_0000, 4'b0000}); // quiet nan in
    tbl.push_back('{1'b0, 254, 28'h800_0000, 4'b0000, 32'h7F80_0000, 4'b0101}); // overflow
    tbl.push_back('{1'b0, 254, 28'h7FF_FFFC, 4'b0000, 32'h7F80_0000, 4'b0101}); // round overflow
    tbl.push_back('{1'b0, 254, 28'h400_0000, 4'b0000, 32'h7F00_0000, 4'b0000}); // max exp
    tbl.push_back('{1'b0,   0, 28'h400_0000, 4'b0000, 32'h0040_0000, 4'b0000}); // subnormal
    tbl.push_back('{1'b0, -40, 28'h400_0000, 4'b0000, 32'h0000_0000, 4'b0011}); // collapse
    tbl.push_back('{1'b0, -26, 28'h800_0000, 4'b0000, 32'h0000_0000, 4'b0011}); // longest path
    tbl.push_back('{1'b0, 127, 28'h400_0004, 4'b0000, 32'h3F80_0000, 4'b0001}); // tie to even
    tbl.push_back('{1'b0,   1, 28'h3FF_FFFC, 4'b0000, 32'h0080_0000, 4'b0001}); // -> min normal
    tbl.push_back('{1'b0, 130, 28'h200_0000, 4'b0000, 32'h4080_0000, 4'b0000}); // left normalise
    tbl.push_back('{1'b1, 100, 28'h000_0000, 4'b0000, 32'h8000_0000, 4'b0000}); // zero sig

    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(tbl[i].sign, tbl[i].exp, tbl[i].sig, tbl[i].st, i % 3, res, fl, lat, ok);
      check($sformatf("vec%0d done", i), ok, 1);
      check($sformatf("vec%0d result", i), res, tbl[i].res);
      check($sformatf("vec%0d flags", i), fl, tbl[i].fl);
      if (tbl[i].st != 4'b0000) check($sformatf("vec%0d special latency", i), lat, 1);
      else check_latency($sformatf("vec%0d latency", i), lat, LAT_MAX);
    end

    // Back-pressure: result held while a new request waits, no same-cycle re-accept.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_sig = 28'h600_0000; in_op_status = '0;
    @(posedge clk);
    #1;
    in_sig = 28'h800_0000;
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("hold first valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold result c%0d", c), out_result, 32'h3FC0_0000);
      check($sformatf("hold in_ready c%0d", c), in_ready, 0);
      check($sformatf("hold out_valid c%0d", c), out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release out_valid", out_valid, 0);
    check("release in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("queued result", out_result, 32'h4000_0000);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in the middle of a long left-normalisation.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd100; in_sig = 28'h000_0001; in_op_status = '0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("busy in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midreset in_ready", in_ready, 1);
    check("midreset out_valid", out_valid, 0);
    check("midreset out_result", out_result, 0);
    check("midreset out_flags", out_flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 127, 28'h600_0000, 4'b0000, 0, res, fl, lat, ok);
    check("post-reset result", res, 32'hBFC0_0000);

    // Random stimulus against the value-level model.
    for (int i = 0; i < 400; i++) begin
      logic        sign;
      int          exp;
      logic [27:0] sig;
      logic [3:0]  st;
      sign = 1'($urandom_range(0, 1));
      exp  = int'($urandom_range(0, 360)) - 60;
      case ($urandom_range(0, 3))
        0:       sig = 28'($urandom);
        1:       sig = 28'($urandom) >> $urandom_range(0, 27);
        2:       sig = {2'b01, 26'($urandom)};
        default: sig = 28'($urandom_range(0, 15));
      endcase
      st = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      want = ref_pack(sign, exp, sig, st);
      run_txn(sign, exp, sig, st, int'($urandom_range(0, 2)), res, fl, lat, ok);
      check($sformatf("rnd%0d done", i), ok, 1);
      check($sformatf("rnd%0d s=%0d e=%0d sig=%0h st=%0h result", i, sign, exp, sig, st),
            res, want[31:0]);
      check($sformatf("rnd%0d flags", i), fl, want[35:32]);
      if (st != 4'b0000) check($sformatf("rnd%0d special latency", i), lat, 1);
      else check_latency($sformatf("rnd%0d latency", i), lat, LAT_MAX);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
